// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and ID/EX control field layout for pipe_stage_reg
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Bit positions inside the ID/EX control vector.
  localparam int REGDST_BIT   = 0;
  localparam int ALUSRC_BIT   = 1;
  localparam int MEMTOREG_BIT = 2;
  localparam int REGWRITE_BIT = 3;
  localparam int MEMREAD_BIT  = 4;
  localparam int MEMWRITE_BIT = 5;
  localparam int BRANCH_BIT   = 6;
  localparam int JUMP_BIT     = 7;
  localparam int ALUOP_LSB    = 8;
  localparam int ALUOP_MSB    = 9;
  localparam int IDEX_CTRL_W  = 10;

  localparam logic [IDEX_CTRL_W-1:0] DEFAULT_CTRL_NOP = '0;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one pipeline storage entry (valid, ctrl, data) with load and clear
module pipe_slot #(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 10,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Clear only drops valid; the payload is kept so out_data holds its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= CTRL_NOP;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ld_ctrl;
      data  <= ld_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline register with stall, flush and NOP forcing
// PIPE_STAGE_REG_SKID_EN adds a skid slot and a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 10,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  state_t            state;
  state_t            state_next;
  logic              in_fire;
  logic              out_fire;
  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              main_load;
  logic              main_clear;
  logic [CTRL_W-1:0] main_ld_ctrl;
  logic [DATA_W-1:0] main_ld_data;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_valid && out_ready;

`ifdef PIPE_STAGE_REG_SKID_EN
  logic              in_ready_q;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              skid_load;
  logic              skid_clear;
  logic              main_from_skid;

  assign in_ready     = in_ready_q;
  assign main_ld_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_ld_data = main_from_skid ? skid_data : in_data;

  always_comb begin
    state_next     = state;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_next = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        EMPTY: if (in_fire) begin
          main_load  = 1'b1;
          state_next = ONE;
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load  = 1'b1;
            state_next = FULL;
          end else if (out_fire) begin
            main_clear = 1'b1;
            state_next = EMPTY;
          end
        end
        FULL: if (out_fire) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clear     = 1'b1;
          state_next     = ONE;
        end
        default: begin
          state_next = EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  // in_ready looks one cycle ahead so out_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != FULL);
    end
  end

  pipe_slot #(
    .DATA_W  (DATA_W),
    .CTRL_W  (CTRL_W),
    .CTRL_NOP(CTRL_NOP)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .clear  (skid_clear),
    .load   (skid_load),
    .ld_ctrl(in_ctrl),
    .ld_data(in_data),
    .valid  (skid_valid),
    .ctrl   (skid_ctrl),
    .data   (skid_data)
  );
`else
  assign in_ready     = !main_valid || out_ready;
  assign main_ld_ctrl = in_ctrl;
  assign main_ld_data = in_data;

  always_comb begin
    state_next = state;
    main_load  = 1'b0;
    main_clear = 1'b0;
    if (flush) begin
      state_next = EMPTY;
      main_clear = 1'b1;
    end else if (in_fire) begin
      main_load  = 1'b1;
      state_next = ONE;
    end else if (out_fire) begin
      main_clear = 1'b1;
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end
`endif

  pipe_slot #(
    .DATA_W  (DATA_W),
    .CTRL_W  (CTRL_W),
    .CTRL_NOP(CTRL_NOP)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .clear  (main_clear),
    .load   (main_load),
    .ld_ctrl(main_ld_ctrl),
    .ld_data(main_ld_data),
    .valid  (main_valid),
    .ctrl   (main_ctrl),
    .data   (main_data)
  );

  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : CTRL_NOP;
  assign out_data  = main_data;

  always_comb begin
    case (state)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W  (DATA_W),
    .CTRL_W  (CTRL_W),
    .CTRL_NOP('0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    offer(32'hDEAD_BEEF, 10'h3FF);
    repeat (3) step();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_data", out_data, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_in_ready", in_ready, 1);

    // Back-to-back stream with no backpressure
    for (int i = 1; i <= 8; i++) begin
      offer(i, i[CTRL_W-1:0]);
      #1;
      check("stream_in_ready", in_ready, 1);
      step();
      check("stream_out_valid", out_valid, 1);
      check("stream_out_data", out_data, i);
      check("stream_out_ctrl", out_ctrl, i);
    end
    in_valid = 1'b0;
    step();
    check("drain_out_valid", out_valid, 0);
    check("drain_occupancy", occupancy, 0);

    // NOP forcing after consumption
    offer(32'h55, 10'h0A4);
    step();
    check("nop_ctrl_live", out_ctrl, 10'h0A4);
    in_valid = 1'b0;
    step();
    check("nop_out_valid", out_valid, 0);
    check("nop_ctrl_forced", out_ctrl, 0);
    check("nop_data_held", out_data, 32'h55);

`ifdef PIPE_STAGE_REG_SKID_EN
    // Stall with skid: A in MAIN, B in SKID, C held upstream
    out_ready = 1'b0;
    offer(32'hA, 10'h00A);
    step();
    check("stall_a_data", out_data, 32'hA);
    check("stall_a_occ", occupancy, 1);
    check("stall_a_in_ready", in_ready, 1);
    offer(32'hB, 10'h00B);
    step();
    check("stall_b_occ", occupancy, 2);
    check("stall_b_in_ready", in_ready, 0);
    check("stall_b_data", out_data, 32'hA);
    offer(32'hC, 10'h00C);
    step();
    check("stall_c_occ", occupancy, 2);
    check("stall_c_data", out_data, 32'hA);
    out_ready = 1'b1;
    step();
    check("rel_b_data", out_data, 32'hB);
    check("rel_b_ctrl", out_ctrl, 10'h00B);
    check("rel_b_occ", occupancy, 1);
    check("rel_b_in_ready", in_ready, 1);
    step();
    check("rel_c_data", out_data, 32'hC);
    check("rel_c_valid", out_valid, 1);
    in_valid = 1'b0;
    step();
    check("rel_empty", out_valid, 0);

    // Flush in FULL with a beat offered
    out_ready = 1'b0;
    offer(32'hE, 10'h00E);
    step();
    offer(32'hF, 10'h00F);
    step();
    check("pre_flush_occ", occupancy, 2);
    flush = 1'b1;
    offer(32'hD, 10'h00D);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_full_valid", out_valid, 0);
    check("flush_full_ctrl", out_ctrl, 0);
    check("flush_full_occ", occupancy, 0);
    check("flush_full_in_ready", in_ready, 1);
    check("flush_full_data_held", out_data, 32'hE);
    out_ready = 1'b1;
    repeat (2) begin
      step();
      check("flush_full_no_d", out_valid, 0);
    end
`else
    // Single slot: in_ready follows out_ready combinationally
    out_ready = 1'b0;
    offer(32'hA, 10'h00A);
    step();
    check("ns_stall_in_ready", in_ready, 0);
    check("ns_stall_occ", occupancy, 1);
    offer(32'hB, 10'h00B);
    step();
    check("ns_stall_data", out_data, 32'hA);
    check("ns_stall_occ_max", occupancy, 1);
    out_ready = 1'b1;
    #1;
    check("ns_release_in_ready", in_ready, 1);
    step();
    check("ns_b_data", out_data, 32'hB);
    check("ns_b_ctrl", out_ctrl, 10'h00B);
    check("ns_b_occ", occupancy, 1);
    in_valid = 1'b0;
    step();
    check("ns_empty", out_valid, 0);
`endif

    // Flush in ONE while the offered beat would otherwise be accepted
    out_ready = 1'b0;
    offer(32'h77, 10'h077);
    step();
    check("one_pre_flush_occ", occupancy, 1);
    out_ready = 1'b1;
    flush = 1'b1;
    offer(32'h99, 10'h099);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_one_valid", out_valid, 0);
    check("flush_one_occ", occupancy, 0);
    check("flush_one_ctrl", out_ctrl, 0);
    check("flush_one_data_held", out_data, 32'h77);
    check("flush_one_in_ready", in_ready, 1);
    step();
    check("flush_one_no_beat", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
